// File: rtl/stop_match_unit.sv
// Multi-channel stop-threshold comparator: each channel holds a loadable threshold and mode,
// runs an IDLE/ARMED/HIT state machine and reports level, pulse, sticky flag and a saturating hit count.

module stop_match_ch #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] comp_a,
  input  logic             comp_valid,
  input  logic             load_we,
  input  logic [WIDTH-1:0] load_val,
  input  logic             load_mode,
  input  logic             arm,
  input  logic             clear,
  output logic             level,
  output logic             pulse,
  output logic             sticky,
  output logic [CNT_W-1:0] hit_cnt
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_HIT   = 2'd2;

  logic [WIDTH-1:0] stop_q, stop_d;
  logic             mode_q, mode_d;
  logic [1:0]       state_q, state_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmp, hit;

  always_comb begin
    // Compare always uses the threshold held before any same-cycle load.
    cmp     = comp_valid && (mode_q ? (comp_a >= stop_q) : (comp_a == stop_q));
    stop_d  = stop_q;
    mode_d  = mode_q;
    if (load_we) begin
      stop_d = load_val;
      mode_d = load_mode;
    end
    level_d = comp_valid ? cmp : level_q;

    hit     = 1'b0;
    state_d = state_q;
    if (clear) begin
      state_d = arm ? S_ARMED : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (arm) state_d = S_ARMED;
        S_ARMED: if (cmp) begin
          state_d = S_HIT;
          hit     = 1'b1;
        end
        S_HIT:   state_d = S_HIT;
        default: state_d = S_IDLE;
      endcase
    end

    pulse_d  = hit;
    // Sticky gets its own flop so the OR-reduction downstream sees clean edges.
    sticky_d = (state_d == S_HIT);
    cnt_d    = (hit && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stop_q   <= '0;
      mode_q   <= 1'b0;
      state_q  <= S_IDLE;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stop_q   <= stop_d;
      mode_q   <= mode_d;
      state_q  <= state_d;
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level   = level_q;
  assign pulse   = pulse_q;
  assign sticky  = sticky_q;
  assign hit_cnt = cnt_q;
endmodule

module stop_match_unit #(
  parameter  int WIDTH  = 6,
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 8,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        CompA,
  input  logic                    CompA_Valid,
  input  logic                    Load_En,
  input  logic [SEL_W-1:0]        Load_Sel,
  input  logic [WIDTH-1:0]        Load_Val,
  input  logic                    Load_Mode,
  input  logic [NUM_CH-1:0]       Arm,
  input  logic [NUM_CH-1:0]       Clear,
  output logic [NUM_CH-1:0]       Match_Level,
  output logic [NUM_CH-1:0]       Match_Pulse,
  output logic [NUM_CH-1:0]       Match_Sticky,
  output logic                    Any_Match,
  output logic [NUM_CH*CNT_W-1:0] Hit_Count
);
  logic [NUM_CH-1:0][CNT_W-1:0] hit_cnt;

  // Out-of-range selects never equal any channel index, so they drop out here.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    stop_match_ch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .reset      (reset),
      .comp_a     (CompA),
      .comp_valid (CompA_Valid),
      .load_we    (Load_En && (Load_Sel == SEL_W'(g))),
      .load_val   (Load_Val),
      .load_mode  (Load_Mode),
      .arm        (Arm[g]),
      .clear      (Clear[g]),
      .level      (Match_Level[g]),
      .pulse      (Match_Pulse[g]),
      .sticky     (Match_Sticky[g]),
      .hit_cnt    (hit_cnt[g])
    );
  end

  assign Hit_Count = hit_cnt;
  assign Any_Match = |Match_Sticky;
endmodule

// File: tb/tb_stop_match_unit.sv
// Bench for stop_match_unit: directed vector table, mid-run async reset, then random traffic
// compared cycle by cycle against a behavioural model of the channel rules.
module tb_stop_match_unit;
  // Five channels give a 3-bit select, so out-of-range indices (5..7) are drivable.
  localparam int WIDTH  = 6;
  localparam int NUM_CH = 5;
  localparam int CNT_W  = 2;
  localparam int SEL_W  = 3;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int IDLE = 0, ARMED = 1, HIT = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [WIDTH-1:0]        CompA, Load_Val;
  logic                    CompA_Valid, Load_En, Load_Mode;
  logic [SEL_W-1:0]        Load_Sel;
  logic [NUM_CH-1:0]       Arm, Clear, Match_Level, Match_Pulse, Match_Sticky;
  logic                    Any_Match;
  logic [NUM_CH*CNT_W-1:0] Hit_Count;

  always #5 clk = ~clk;

  stop_match_unit #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .CompA(CompA), .CompA_Valid(CompA_Valid),
    .Load_En(Load_En), .Load_Sel(Load_Sel), .Load_Val(Load_Val), .Load_Mode(Load_Mode),
    .Arm(Arm), .Clear(Clear), .Match_Level(Match_Level), .Match_Pulse(Match_Pulse),
    .Match_Sticky(Match_Sticky), .Any_Match(Any_Match), .Hit_Count(Hit_Count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int m_stop[NUM_CH], m_mode[NUM_CH], m_st[NUM_CH], m_cnt[NUM_CH];
  bit m_lvl[NUM_CH], m_pls[NUM_CH];

  typedef struct {
    logic [5:0] ca; logic vld; logic ld; logic [2:0] sel; logic [5:0] val; logic md;
    logic [4:0] arm; logic [4:0] clr;
    int ch; logic e_lvl; logic e_stk; int e_cnt; logic e_any; logic [4:0] e_pv;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_stop[i] = 0; m_mode[i] = 0; m_st[i] = IDLE; m_cnt[i] = 0; m_lvl[i] = 0; m_pls[i] = 0;
    end
  endtask

  task automatic model_step();
    bit cmp;
    for (int i = 0; i < NUM_CH; i++) begin
      cmp = CompA_Valid && (m_mode[i] != 0 ? int'(CompA) >= m_stop[i] : int'(CompA) == m_stop[i]);
      m_pls[i] = 0;
      if (Clear[i]) m_st[i] = Arm[i] ? ARMED : IDLE;
      else if (m_st[i] == IDLE && Arm[i]) m_st[i] = ARMED;
      else if (m_st[i] == ARMED && cmp) begin
        m_st[i] = HIT; m_pls[i] = 1;
        if (m_cnt[i] < CMAX) m_cnt[i]++;
      end
      if (CompA_Valid) m_lvl[i] = cmp;
    end
    if (Load_En && int'(Load_Sel) < NUM_CH) begin
      m_stop[Load_Sel] = int'(Load_Val);
      m_mode[Load_Sel] = int'(Load_Mode);
    end
  endtask

  task automatic model_check();
    logic [NUM_CH-1:0] el, ep, es;
    logic [NUM_CH*CNT_W-1:0] ec;
    for (int i = 0; i < NUM_CH; i++) begin
      el[i] = m_lvl[i]; ep[i] = m_pls[i]; es[i] = (m_st[i] == HIT);
      ec[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    end
    chk("model_level",  32'(Match_Level),  32'(el));
    chk("model_pulse",  32'(Match_Pulse),  32'(ep));
    chk("model_sticky", 32'(Match_Sticky), 32'(es));
    chk("model_any",    32'(Any_Match),    32'(|es));
    chk("model_count",  32'(Hit_Count),    32'(ec));
  endtask

  task automatic apply(input logic [5:0] ca, input logic v, input logic ld, input logic [2:0] sel,
                       input logic [5:0] val, input logic md, input logic [4:0] arm, input logic [4:0] clr);
    CompA = ca; CompA_Valid = v; Load_En = ld; Load_Sel = sel; Load_Val = val; Load_Mode = md;
    Arm = arm; Clear = clr;
    model_step();
    @(posedge clk); #1;
    model_check();
  endtask

  task automatic add(input logic [5:0] ca, input logic v, input logic ld, input logic [2:0] sel,
                     input logic [5:0] val, input logic md, input logic [4:0] arm, input logic [4:0] clr,
                     input int ch, input logic lvl, input logic pls, input logic stk, input int cnt, input logic any);
    vec_t t;
    t.ca = ca; t.vld = v; t.ld = ld; t.sel = sel; t.val = val; t.md = md; t.arm = arm; t.clr = clr;
    t.ch = ch; t.e_lvl = lvl; t.e_stk = stk; t.e_cnt = cnt; t.e_any = any;
    t.e_pv = pls ? 5'(1 << ch) : 5'b0;
    tbl.push_back(t);
  endtask

  initial begin
    logic [5:0] rca, rval;
    logic [2:0] rsel;
    logic [4:0] rarm, rclr;
    logic rv, rld, rmd;

    reset = 1'b1; CompA = '0; CompA_Valid = 0; Load_En = 0; Load_Sel = '0; Load_Val = '0;
    Load_Mode = 0; Arm = '0; Clear = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    model_check();
    reset = 1'b0;

    // Equal mode on ch1 = 25, ramp 20..30
    add(0, 0, 1, 1, 25, 0, 5'b00000, 5'b00000, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 5'b00010, 5'b00000, 1, 0, 0, 0, 0, 0);
    for (int c = 20; c <= 30; c++)
      add(6'(c), 1, 0, 0, 0, 0, 5'b0, 5'b0, 1, c == 25, c == 25, c >= 25, c >= 25, c >= 25);
    // GE mode on ch2 = 60 with wrap past 63
    add(0, 0, 1, 2, 60, 1, 5'b00000, 5'b00000, 2, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 5'b00100, 5'b00000, 2, 0, 0, 0, 0, 1);
    add(58, 1, 0, 0, 0, 0, 5'b0, 5'b0, 2, 0, 0, 0, 0, 1);
    add(59, 1, 0, 0, 0, 0, 5'b0, 5'b0, 2, 0, 0, 0, 0, 1);
    add(60, 1, 0, 0, 0, 0, 5'b0, 5'b0, 2, 1, 1, 1, 1, 1);
    add(61, 1, 0, 0, 0, 0, 5'b0, 5'b0, 2, 1, 0, 1, 1, 1);
    add(62, 1, 0, 0, 0, 0, 5'b0, 5'b0, 2, 1, 0, 1, 1, 1);
    add(63, 1, 0, 0, 0, 0, 5'b0, 5'b0, 2, 1, 0, 1, 1, 1);
    add(0,  1, 0, 0, 0, 0, 5'b0, 5'b0, 2, 0, 0, 1, 1, 1);
    add(1,  1, 0, 0, 0, 0, 5'b0, 5'b0, 2, 0, 0, 1, 1, 1);
    // Clear beats a match while ARMED
    add(0,  0, 0, 0, 0, 0, 5'b00010, 5'b00010, 1, 0, 0, 0, 1, 1);
    add(25, 1, 0, 0, 0, 0, 5'b00000, 5'b00010, 1, 1, 0, 0, 1, 1);
    add(25, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 1, 1, 0, 0, 1, 1);
    // Clear+Arm from HIT re-arms
    add(0,  1, 0, 0, 0, 0, 5'b00010, 5'b00000, 1, 0, 0, 0, 1, 1);
    add(25, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 1, 1, 1, 1, 2, 1);
    add(25, 1, 0, 0, 0, 0, 5'b00010, 5'b00010, 1, 1, 0, 0, 2, 1);
    add(25, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 1, 1, 1, 1, 3, 1);
    // Same-cycle load uses the old threshold; counter already saturated at 3
    add(0,  0, 0, 0, 0, 0, 5'b00010, 5'b00010, 1, 1, 0, 0, 3, 1);
    add(25, 1, 1, 1, 30, 0, 5'b00000, 5'b00000, 1, 1, 1, 1, 3, 1);
    add(0,  0, 0, 0, 0, 0, 5'b00010, 5'b00010, 1, 1, 0, 0, 3, 1);
    add(25, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 1, 0, 0, 0, 3, 1);
    add(30, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 1, 1, 1, 1, 3, 1);
    // ch0 counter saturation: 1,2,3,3,3
    for (int k = 1; k <= 5; k++) begin
      add(0, 0, 0, 0, 0, 0, 5'b00001, 5'b00001, 0, k != 1, 0, 0, (k - 1 > CMAX) ? CMAX : k - 1, 1);
      add(0, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 1, 1, (k > CMAX) ? CMAX : k, 1);
    end
    // Valid gating and simultaneous hits on ch0 and ch3
    add(0,  0, 1, 0, 10, 0, 5'b00001, 5'b00001, 0, 1, 0, 0, 3, 1);
    add(0,  0, 1, 3, 10, 0, 5'b01000, 5'b00000, 3, 1, 0, 0, 0, 1);
    add(10, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 0, 0, 3, 1);
    add(10, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 1, 1, 1, 3, 1);
    tbl[$].e_pv = 5'b01001;
    // Out-of-range select must not reach ch4
    add(0,  0, 1, 5, 33, 1, 5'b00000, 5'b00000, 4, 0, 0, 0, 0, 1);
    add(0,  0, 0, 0, 0, 0, 5'b10000, 5'b00000, 4, 0, 0, 0, 0, 1);
    add(40, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 4, 0, 0, 0, 0, 1);

    foreach (tbl[r]) begin
      apply(tbl[r].ca, tbl[r].vld, tbl[r].ld, tbl[r].sel, tbl[r].val, tbl[r].md, tbl[r].arm, tbl[r].clr);
      chk($sformatf("row%0d_level", r),  32'(Match_Level[tbl[r].ch]), 32'(tbl[r].e_lvl));
      chk($sformatf("row%0d_sticky", r), 32'(Match_Sticky[tbl[r].ch]), 32'(tbl[r].e_stk));
      chk($sformatf("row%0d_count", r),  32'(Hit_Count[tbl[r].ch*CNT_W +: CNT_W]), 32'(tbl[r].e_cnt));
      chk($sformatf("row%0d_pulse", r),  32'(Match_Pulse), 32'(tbl[r].e_pv));
      chk($sformatf("row%0d_any", r),    32'(Any_Match), 32'(tbl[r].e_any));
    end

    // Asynchronous reset mid-cycle with ch0 in HIT
    chk("pre_reset_sticky0", 32'(Match_Sticky[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_level",  32'(Match_Level),  32'd0);
    chk("async_rst_pulse",  32'(Match_Pulse),  32'd0);
    chk("async_rst_sticky", 32'(Match_Sticky), 32'd0);
    chk("async_rst_any",    32'(Any_Match),    32'd0);
    chk("async_rst_count",  32'(Hit_Count),    32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    apply(0, 1, 0, 0, 0, 0, 5'b0, 5'b0);
    chk("post_rst_level0",  32'(Match_Level[0]), 32'd1);
    chk("post_rst_sticky",  32'(Match_Sticky),   32'd0);

    for (int k = 0; k < 600; k++) begin
      rca  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      rv   = ($urandom_range(0, 3) != 0);
      rld  = ($urandom_range(0, 4) == 0);
      rsel = 3'($urandom_range(0, 7));
      rval = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      rmd  = 1'($urandom_range(0, 1));
      rarm = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
      rclr = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
      apply(rca, rv, rld, rsel, rval, rmd, rarm, rclr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
